data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024, meaning memory size in bytes (power of 2, multiple of 4, min 16).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning request address width.
REQ-003 The block SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_valid  in  1  request present.
REQ-006 The block SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high at a clock edge.
REQ-007 The block SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = word.
REQ-009 The block SHALL have port req_unsigned  in  1  load zero-extends when set, sign-extends otherwise.
REQ-010 The block SHALL have port req_addr  in  ADDR_W  byte address.
REQ-011 The block SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-012 The block SHALL have port rsp_valid  out  1  response present.
REQ-013 The block SHALL have port rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-014 The block SHALL have port rsp_rdata  out  32  load data; 0 for stores and errors.
REQ-015 The block SHALL have port rsp_err  out  1  access faulted.
REQ-016 The block SHALL have port init_done  out  1  memory initialisation complete.

Function
REQ-017 Byte order SHALL be big-endian: the byte at address a is the most significant byte, so a word load returns {m[a],m[a+1],m[a+2],m[a+3]}.
REQ-018 Effective address SHALL be req_addr modulo DEPTH; upper bits are ignored, and an access at DEPTH wraps to 0.
REQ-019 The FSM SHALL have states INIT, IDLE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 INIT: the block SHALL write zero to one word per cycle for DEPTH/4 cycles, then set init_done=1 and enter IDLE; init_done SHALL then stay 1 until reset.
REQ-021 IDLE: on acceptance the block SHALL perform the access and enter RESP on the next edge, with rsp_valid=1 exactly one cycle after acceptance.
REQ-022 RESP: the block SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE; there SHALL be no back-to-back acceptance, giving a maximum throughput of 1 access per 2 cycles.
REQ-023 Stores SHALL write as follows: byte m[a]=wdata[7:0]; half m[a]=wdata[15:8], m[a+1]=wdata[7:0]; word m[a..a+3]=wdata[31:24..7:0]. Untouched bytes SHALL be preserved.
REQ-024 Loads SHALL place the byte or half in rsp_rdata[7:0] or [15:0], with upper bits zero- or sign-extended per req_unsigned; for words, req_unsigned SHALL be ignored.
REQ-025 A store SHALL respond with rsp_rdata=0 and rsp_err=0.

Reset
REQ-026 On rst assertion the block SHALL immediately set state=INIT, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, init counter=0.
REQ-027 Reset mid-operation SHALL drop any pending response without delivering it; an in-flight store completes or is lost, and either way is overwritten by INIT.
REQ-028 After rst deasserts, the block SHALL re-run INIT in full (DEPTH/4 cycles) before accepting a request.

Configuration
REQ-029 With macro DMEM_MISALIGN_TRAP_EN defined, a misaligned access (half with a[0]=1; word with a[1:0]!=0) SHALL respond with rsp_err=1 and rsp_rdata=0, and memory SHALL not be modified.
REQ-030 Without DMEM_MISALIGN_TRAP_EN, the block SHALL clear the low address bits to natural alignment, perform the access, and drive rsp_err=0.

Structure
REQ-031 The shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-032 The block SHALL contain one sub-module, dmem_bank: a byte-wide synchronous RAM of DEPTH/4 entries, instantiated 4 times (one per byte lane, lane 0 = most significant byte).

Verification
REQ-033 Reset then idle: init_done rises after exactly DEPTH/4 cycles (256 at the default), and a word load at 0x10 returns 0x00000000.
REQ-034 Store word 0x11223344 at 0x8, then load byte 0x9 signed -> 0x00000022, load half 0x8 -> 0x00001122, load word 0x8 -> 0x11223344.
REQ-035 Store byte 0x80 at 0x4, then load byte 0x4 signed -> 0xFFFFFF80, unsigned -> 0x00000080; bytes 0x5..0x7 stay 0.
REQ-036 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0 throughout; after the ready handshake, req_ready=1 on the next cycle.
REQ-037 Word load at 0x6: with DMEM_MISALIGN_TRAP_EN -> rsp_err=1, rdata=0; without it -> returns the word at 0x4 with rsp_err=0. Word store at address DEPTH+4 -> a subsequent load at 0x4 returns that data.
REQ-038 Assert rst while in RESP -> rsp_valid drops immediately and no response is delivered; after INIT, memory reads as all zero.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-laned data memory controller:
// access size encodings, FSM state enum, captured request bundle.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Request attributes held from acceptance until the response is consumed
    typedef struct packed {
        logic [1:0] size;
        logic [1:0] off;
        logic       uns;
        logic       we;
        logic       err;
    } dmem_req_t;

    // Pick the addressed byte/half out of a big-endian word and extend it
    function automatic logic [31:0] load_format(
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        unique case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        if (size == SZ_BYTE) begin
            r = {{24{~uns & b[7]}}, b};
        end else if (size == SZ_HALF) begin
            r = {{16{~uns & h[15]}}, h};
        end else begin
            r = word;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: synchronous single-port RAM
// with registered read data (read-before-write on a shared address).
module dmem_bank #(
    parameter int ENTRIES = 256,
    parameter int AW      = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [ENTRIES];

    // Single access port: optional write, read data captured every enabled cycle
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Big-endian byte/half/word data memory with valid/ready request and
// response channels. Optional misaligned-access trap: DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int BYTE_AW = $clog2(DEPTH);
    localparam int WORDS   = DEPTH / 4;
    localparam int WORD_AW = BYTE_AW - 2;

    dmem_state_t        state_q;
    dmem_state_t        state_d;
    logic [WORD_AW-1:0] init_cnt_q;
    dmem_req_t          req_q;
    dmem_req_t          req_d;

    logic [BYTE_AW-1:0] ea;
    logic               is_byte;
    logic               is_half;
    logic               err;
    logic               accept;
    logic [3:0]         lane_sel;
    logic [31:0]        wdata_rep;

    logic               bank_en;
    logic [3:0]         lane_we;
    logic [WORD_AW-1:0] bank_addr;
    logic [31:0]        bank_wdata;
    logic [31:0]        bank_rdata;

    logic               unused_addr_bits;

    // Address bits above the memory size are deliberately ignored (wrap)
    assign unused_addr_bits = ^req_addr[ADDR_W-1:BYTE_AW];

    assign accept = (state_q == ST_IDLE) && req_valid;

    // Decode size, align the effective address and derive lane enables/data
    always_comb begin
        is_byte = (req_size == SZ_BYTE);
        is_half = (req_size == SZ_HALF);
        ea      = req_addr[BYTE_AW-1:0];
        if (is_half) begin
            ea[0] = 1'b0;
        end else if (!is_byte) begin
            ea[1:0] = 2'b00;
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        err = is_half ? req_addr[0]
                      : (!is_byte && (req_addr[1:0] != 2'b00));
`else
        err = 1'b0;
`endif
        if (is_byte) begin
            lane_sel  = 4'b0001 << ea[1:0];
            wdata_rep = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            lane_sel  = ea[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{req_wdata[15:0]}};
        end else begin
            lane_sel  = 4'b1111;
            wdata_rep = req_wdata;
        end
    end

    // Capture the request attributes needed to shape the response
    always_comb begin
        req_d      = '0;
        req_d.size = req_size;
        req_d.off  = ea[1:0];
        req_d.uns  = req_unsigned;
        req_d.we   = req_we;
        req_d.err  = err;
    end

    // Bank port: INIT zero-fill has priority, else the accepted request
    always_comb begin
        bank_en    = 1'b0;
        lane_we    = 4'b0000;
        bank_addr  = ea[BYTE_AW-1:2];
        bank_wdata = wdata_rep;
        if (state_q == ST_INIT) begin
            bank_en    = 1'b1;
            lane_we    = 4'b1111;
            bank_addr  = init_cnt_q;
            bank_wdata = '0;
        end else if (accept) begin
            bank_en = 1'b1;
            if (req_we && !err) begin
                lane_we = lane_sel;
            end
        end
    end

    // Next-state logic: INIT -> IDLE -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: if (&init_cnt_q) state_d = ST_IDLE;
            ST_IDLE: if (req_valid)   state_d = ST_RESP;
            ST_RESP: if (rsp_ready)   state_d = ST_IDLE;
            default:                  state_d = ST_INIT;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Zero-fill word counter, advances only while initialising
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + WORD_AW'(1);
        end
    end

    // Hold request attributes for the duration of the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= req_d;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        dmem_bank #(
            .ENTRIES (WORDS),
            .AW      (WORD_AW)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en),
            .we    (lane_we[k]),
            .addr  (bank_addr),
            .wdata (bank_wdata[31-8*k -: 8]),
            .rdata (bank_rdata[31-8*k -: 8])
        );
    end

    // Outputs decode from state so reset drops them immediately;
    // banks are idle in RESP so the read data stays stable.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        init_done = (state_q != ST_INIT);
        rsp_err   = rsp_valid && req_q.err;
        rsp_rdata = '0;
        if (rsp_valid && !req_q.we && !req_q.err) begin
            rsp_rdata = load_format(req_q.size, req_q.off,
                                    req_q.uns, bank_rdata);
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (DEPTH=1024).
// Honours DMEM_MISALIGN_TRAP_EN for the misalignment expectations.
module tb_data_mem_ctrl;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    int total;
    int bad;

    data_mem_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request, wait for its response, consume it
    task automatic do_access(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        output logic [31:0] rdata,
        output logic        err
    );
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL req_timeout addr=%h got ready=%b want 1", addr, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rsp_latency addr=%h got valid=%b want 1", addr, rsp_valid);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int  n;
        logic rdy_seen;
        logic [31:0] d;
        logic e;
        repeat (3) @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_err, init_done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got %b want 0000",
                     {req_ready, rsp_valid, rsp_err, init_done});
        end
        total++;
        if (rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata got %h want 00000000", rsp_rdata);
        end
        rst = 1'b0;
        n = 0;
        rdy_seen = 1'b0;
        while (init_done !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (init_done !== 1'b1 && req_ready !== 1'b0) rdy_seen = 1'b1;
        end
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL init_cycles got %0d want 256", n);
        end
        total++;
        if (rdy_seen !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_init got 1 want 0");
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, d, e);
        total++;
        if ({e, d} !== 33'h0) begin
            bad++;
            $display("FAIL load_after_init got err=%b d=%h want 0/00000000", e, d);
        end
    endtask

    task automatic test_word();
        logic [31:0] d;
        logic e;
        do_access(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, d, e);
        total++;
        if ({e, d} !== 33'h0) begin
            bad++;
            $display("FAIL store_rsp got err=%b d=%h want 0/00000000", e, d);
        end
        do_access(1'b0, 2'd0, 1'b0, 32'h9, 32'h0, d, e);
        total++;
        if (d !== 32'h00000022) begin
            bad++;
            $display("FAIL ld_b9 got %h want 00000022", d);
        end
        do_access(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, d, e);
        total++;
        if (d !== 32'h00001122) begin
            bad++;
            $display("FAIL ld_h8 got %h want 00001122", d);
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, d, e);
        total++;
        if (d !== 32'h11223344) begin
            bad++;
            $display("FAIL ld_w8 got %h want 11223344", d);
        end
        do_access(1'b0, 2'd3, 1'b1, 32'h8, 32'h0, d, e);
        total++;
        if (d !== 32'h11223344) begin
            bad++;
            $display("FAIL ld_sz3 got %h want 11223344", d);
        end
        do_access(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, d, e);
        total++;
        if (d !== 32'h00003344) begin
            bad++;
            $display("FAIL ld_hA got %h want 00003344", d);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] d;
        logic e;
        do_access(1'b1, 2'd0, 1'b0, 32'h4, 32'h12345680, d, e);
        do_access(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, d, e);
        total++;
        if (d !== 32'hFFFFFF80) begin
            bad++;
            $display("FAIL ld_b4_s got %h want ffffff80", d);
        end
        do_access(1'b0, 2'd0, 1'b1, 32'h4, 32'h0, d, e);
        total++;
        if (d !== 32'h00000080) begin
            bad++;
            $display("FAIL ld_b4_u got %h want 00000080", d);
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, d, e);
        total++;
        if (d !== 32'h80000000) begin
            bad++;
            $display("FAIL ld_w4 got %h want 80000000", d);
        end
        do_access(1'b1, 2'd1, 1'b0, 32'hE, 32'hAAAABEEF, d, e);
        do_access(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, d, e);
        total++;
        if (d !== 32'h0000BEEF) begin
            bad++;
            $display("FAIL ld_wC got %h want 0000beef", d);
        end
        do_access(1'b0, 2'd1, 1'b0, 32'hE, 32'h0, d, e);
        total++;
        if (d !== 32'hFFFFBEEF) begin
            bad++;
            $display("FAIL ld_hE got %h want ffffbeef", d);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h8;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11223344 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d got v=%b d=%h r=%b want 1/11223344/0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL after_hs got r=%b v=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_align_wrap();
        logic [31:0] d;
        logic e;
        do_access(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, d, e);
        total++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (e !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL ld_w6 got err=%b d=%h want 1/00000000", e, d);
        end
`else
        if (e !== 1'b0 || d !== 32'h80000000) begin
            bad++;
            $display("FAIL ld_w6 got err=%b d=%h want 0/80000000", e, d);
        end
`endif
        do_access(1'b1, 2'd2, 1'b0, DEPTH + 4, 32'hCAFEF00D, d, e);
        do_access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, d, e);
        total++;
        if (d !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL wrap_w4 got %h want cafef00d", d);
        end
        do_access(1'b0, 2'd0, 1'b1, DEPTH + 7, 32'h0, d, e);
        total++;
        if (d !== 32'h0000000D) begin
            bad++;
            $display("FAIL wrap_b7 got %h want 0000000d", d);
        end
        do_access(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, d, e);
        total++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (e !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL ld_h5 got err=%b d=%h want 1/00000000", e, d);
        end
`else
        if (e !== 1'b0 || d !== 32'hFFFFCAFE) begin
            bad++;
            $display("FAIL ld_h5 got err=%b d=%h want 0/ffffcafe", e, d);
        end
`endif
        do_access(1'b1, 2'd2, 1'b0, 32'h6, 32'h01020304, d, e);
        do_access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, d, e);
        total++;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (d !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL mis_st got %h want cafef00d", d);
        end
`else
        if (d !== 32'h01020304) begin
            bad++;
            $display("FAIL mis_st got %h want 01020304", d);
        end
`endif
    endtask

    task automatic test_reset_in_resp();
        int n;
        logic [31:0] d;
        logic e;
        do_access(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, d, e);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL pre_rst got v=%b d=%h want 1/deadbeef", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({rsp_valid, rsp_err, req_ready, init_done} !== 4'b0000 || rsp_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_drop got v=%b e=%b r=%b i=%b d=%h want 0/0/0/0/0",
                     rsp_valid, rsp_err, req_ready, init_done, rsp_rdata);
        end
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        rst = 1'b0;
        n = 0;
        while (init_done !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (n != 256 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reinit got cycles=%0d v=%b want 256/0", n, rsp_valid);
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, d, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL zero_20 got %h want 00000000", d);
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, d, e);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL zero_8 got %h want 00000000", d);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        test_reset();
        test_word();
        test_byte_half();
        test_backpressure();
        test_align_wrap();
        test_reset_in_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
